// File: rtl/dma_controller_channel_arbiter.sv
// Priority arbiter for DMA channels: highest priority wins, ties rotate round-robin
// from the last granted channel; a grant lasts until done or the channel is disabled.
module dma_controller_channel_arbiter #(
    parameter int CHANNELS_AMOUNT = 4,
    parameter int CH_IDX_W        = $clog2(CHANNELS_AMOUNT)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS_AMOUNT-1:0]     channel_en,
    input  logic [2*CHANNELS_AMOUNT-1:0]   channel_priority,
    input  logic [CHANNELS_AMOUNT-1:0]     req,
    input  logic                           done,
    output logic [CHANNELS_AMOUNT-1:0]     grant,
    output logic                           grant_valid,
    output logic [CH_IDX_W-1:0]            grant_idx,
    output logic                           abort
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                       state_reg, state_next;
    logic [CHANNELS_AMOUNT-1:0]   grant_reg, grant_next;
    logic [CH_IDX_W-1:0]          grant_idx_reg, grant_idx_next;
    logic [CH_IDX_W-1:0]          last_idx_reg, last_idx_next;
    logic                         abort_reg, abort_next;

    logic [CHANNELS_AMOUNT-1:0]   eligible;
    logic [CHANNELS_AMOUNT-1:0]   top_prio;
    logic [1:0]                   prio [CHANNELS_AMOUNT];
    logic [1:0]                   max_prio;
    logic [CH_IDX_W:0]            pos;
    logic [CH_IDX_W-1:0]          winner_idx;
    logic                         winner_found;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS_AMOUNT; gi++) begin : g_chan
            assign eligible[gi] = req[gi] & channel_en[gi];
            assign prio[gi]     = channel_priority[2*gi+1 : 2*gi];
            assign top_prio[gi] = eligible[gi] && (prio[gi] == max_prio);
        end
    endgenerate

    always_comb begin
        max_prio = 2'd0;
        for (int i = 0; i < CHANNELS_AMOUNT; i++) begin
            if (eligible[i] && (prio[i] > max_prio)) begin
                max_prio = prio[i];
            end
        end
    end

    // Scan tied channels starting just after the last granted one, wrapping around.
    always_comb begin
        pos          = '0;
        winner_idx   = '0;
        winner_found = 1'b0;
        for (int k = 0; k < CHANNELS_AMOUNT; k++) begin
            pos = {1'b0, last_idx_reg} + (CH_IDX_W+1)'(k + 1);
            if (pos >= (CH_IDX_W+1)'(CHANNELS_AMOUNT)) begin
                pos = pos - (CH_IDX_W+1)'(CHANNELS_AMOUNT);
            end
            if (!winner_found && top_prio[pos[CH_IDX_W-1:0]]) begin
                winner_found = 1'b1;
                winner_idx   = pos[CH_IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= '0;
            grant_idx_reg <= '0;
            last_idx_reg  <= CH_IDX_W'(CHANNELS_AMOUNT - 1);
            abort_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            grant_idx_reg <= grant_idx_next;
            last_idx_reg  <= last_idx_next;
            abort_reg     <= abort_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        grant_idx_next = grant_idx_reg;
        last_idx_next  = last_idx_reg;
        abort_next     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (winner_found) begin
                    state_next             = ST_GRANT;
                    grant_next             = '0;
                    grant_next[winner_idx] = 1'b1;
                    grant_idx_next         = winner_idx;
                end
            end
            ST_GRANT: begin
                // done takes precedence over a simultaneous disable, so no abort then.
                if (done || !channel_en[grant_idx_reg]) begin
                    state_next     = ST_RELEASE;
                    grant_next     = '0;
                    grant_idx_next = '0;
                    last_idx_next  = grant_idx_reg;
                    abort_next     = !done;
                end
            end
            ST_RELEASE: begin
                state_next     = ST_IDLE;
                grant_next     = '0;
                grant_idx_next = '0;
            end
            default: begin
                state_next     = ST_IDLE;
                grant_next     = '0;
                grant_idx_next = '0;
            end
        endcase
    end

    assign grant       = grant_reg;
    assign grant_valid = |grant_reg;
    assign grant_idx   = grant_idx_reg;
    assign abort       = abort_reg;

endmodule

// File: tb/tb_dma_controller_channel_arbiter.sv
// Directed-vector bench for the DMA channel arbiter (4 channels).
module tb_dma_controller_channel_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] channel_en;
    logic [7:0] channel_priority;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       abort;

    int n_checks = 0;
    int n_pass   = 0;

    dma_controller_channel_arbiter #(
        .CHANNELS_AMOUNT(4),
        .CH_IDX_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .channel_en(channel_en),
        .channel_priority(channel_priority),
        .req(req),
        .done(done),
        .grant(grant),
        .grant_valid(grant_valid),
        .grant_idx(grant_idx),
        .abort(abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse done, then leave the arbiter in IDLE ready to arbitrate at the next edge.
    task automatic finish_grant();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; channel_en = 4'b1111;
        channel_priority = 8'h55; done = 1'b0;
        tick(); tick();
        n_checks++;
        if ({grant, grant_valid, grant_idx, abort} !== 8'b0) $display("FAIL reset_outputs: grant=%b gv=%b idx=%0d abort=%b, required all 0", grant, grant_valid, grant_idx, abort);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0001;
        rst = 1'b0;
        tick();
        n_checks++;
        if (grant !== 4'b0001 || grant_valid !== 1'b1 || grant_idx !== 2'd0) $display("FAIL rr_first: grant=%b gv=%b idx=%0d, required 0001 1 0", grant, grant_valid, grant_idx);
        else n_pass++;
        tick(); tick();
        n_checks++;
        if (grant !== 4'b0001) $display("FAIL rr_hold: grant=%b, required 0001", grant);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            done = 1'b1;
            tick();
            n_checks++;
            if (grant !== 4'b0000 || grant_valid !== 1'b0) $display("FAIL rr_release_%0d: grant=%b gv=%b, required 0000 0", i, grant, grant_valid);
            else n_pass++;
            // done held through RELEASE must be ignored
            tick();
            done = 1'b0;
            n_checks++;
            if (grant !== 4'b0000) $display("FAIL rr_idle_%0d: grant=%b, required 0000", i, grant);
            else n_pass++;
            tick();
            n_checks++;
            if (grant !== exp_seq[i] || grant_valid !== 1'b1) $display("FAIL rr_grant_%0d: grant=%b gv=%b, required %b 1", i, grant, grant_valid, exp_seq[i]);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        finish_grant();
        req = 4'b0110; channel_priority = 8'h34;
        tick();
        n_checks++;
        if (grant !== 4'b0100 || grant_idx !== 2'd2) $display("FAIL prio_high: grant=%b idx=%0d, required 0100 2", grant, grant_idx);
        else n_pass++;
        finish_grant();
        req = 4'b0010;
        tick();
        n_checks++;
        if (grant !== 4'b0010 || grant_idx !== 2'd1) $display("FAIL prio_remaining: grant=%b idx=%0d, required 0010 1", grant, grant_idx);
        else n_pass++;
    endtask

    task automatic test_abort();
        finish_grant();
        req = 4'b0001; channel_priority = 8'h55;
        tick();
        n_checks++;
        if (grant !== 4'b0001) $display("FAIL abort_setup: grant=%b, required 0001", grant);
        else n_pass++;
        channel_en = 4'b1110; req = 4'b1111;
        tick();
        n_checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || abort !== 1'b1) $display("FAIL abort_pulse: grant=%b gv=%b abort=%b, required 0000 0 1", grant, grant_valid, abort);
        else n_pass++;
        tick();
        n_checks++;
        if (abort !== 1'b0 || grant !== 4'b0000) $display("FAIL abort_one_cycle: abort=%b grant=%b, required 0 0000", abort, grant);
        else n_pass++;
        tick();
        n_checks++;
        if (grant !== 4'b0010 || abort !== 1'b0) $display("FAIL abort_rearb: grant=%b abort=%b, required 0010 0", grant, abort);
        else n_pass++;
    endtask

    task automatic test_done_and_disable();
        finish_grant();
        channel_en = 4'b1111; req = 4'b1000;
        tick();
        n_checks++;
        if (grant !== 4'b1000 || grant_idx !== 2'd3) $display("FAIL dd_setup: grant=%b idx=%0d, required 1000 3", grant, grant_idx);
        else n_pass++;
        done = 1'b1; channel_en = 4'b0111;
        tick();
        done = 1'b0;
        n_checks++;
        if (grant !== 4'b0000 || abort !== 1'b0) $display("FAIL dd_no_abort: grant=%b abort=%b, required 0000 0", grant, abort);
        else n_pass++;
        tick();
        n_checks++;
        if (abort !== 1'b0) $display("FAIL dd_no_abort_late: abort=%b, required 0", abort);
        else n_pass++;
    endtask

    task automatic test_no_preempt();
        channel_en = 4'b1111; req = 4'b0110; channel_priority = 8'h55;
        tick();
        n_checks++;
        if (grant !== 4'b0010) $display("FAIL np_setup: grant=%b, required 0010", grant);
        else n_pass++;
        channel_priority = 8'h75;
        tick(); tick();
        n_checks++;
        if (grant !== 4'b0010) $display("FAIL np_hold: grant=%b, required 0010", grant);
        else n_pass++;
        req = 4'b0100;
        tick();
        n_checks++;
        if (grant !== 4'b0010 || grant_valid !== 1'b1) $display("FAIL np_req_drop: grant=%b gv=%b, required 0010 1", grant, grant_valid);
        else n_pass++;
        finish_grant();
        req = 4'b0110;
        tick();
        n_checks++;
        if (grant !== 4'b0100 || grant_idx !== 2'd2) $display("FAIL np_after: grant=%b idx=%0d, required 0100 2", grant, grant_idx);
        else n_pass++;
    endtask

    task automatic test_reset_mid_grant();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({grant, grant_valid, grant_idx, abort} !== 8'b0) $display("FAIL rst_mid: grant=%b gv=%b idx=%0d abort=%b, required all 0", grant, grant_valid, grant_idx, abort);
        else n_pass++;
        rst = 1'b0; req = 4'b1111; channel_en = 4'b1111; channel_priority = 8'h55;
        tick();
        n_checks++;
        if (grant !== 4'b0001 || grant_idx !== 2'd0 || abort !== 1'b0) $display("FAIL rst_first: grant=%b idx=%0d abort=%b, required 0001 0 0", grant, grant_idx, abort);
        else n_pass++;
    endtask

    task automatic test_not_eligible();
        finish_grant();
        channel_en = 4'b0000; req = 4'b1111;
        tick(); tick();
        n_checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0) $display("FAIL noelig_disabled: grant=%b gv=%b, required 0000 0", grant, grant_valid);
        else n_pass++;
        channel_en = 4'b1000; req = 4'b0111;
        tick(); tick();
        n_checks++;
        if (grant !== 4'b0000) $display("FAIL noelig_mismatch: grant=%b, required 0000", grant);
        else n_pass++;
        req = 4'b1111;
        tick();
        n_checks++;
        if (grant !== 4'b1000 || grant_idx !== 2'd3) $display("FAIL noelig_enable: grant=%b idx=%0d, required 1000 3", grant, grant_idx);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_priority();
        test_abort();
        test_done_and_disable();
        test_no_preempt();
        test_reset_mid_grant();
        test_not_eligible();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
